// File: rtl/line_ram_pkg.sv
// Shared constants for the line-buffer RAM arbiter: owner encoding and default widths.
// No logic, so there is no latency.
// No flow control at this level.
package line_ram_pkg;
   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   // Who currently holds the RAM lock (also reused for "last served")
   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_A    = 2'd1;
   localparam logic [1:0] OWN_B    = 2'd2;
endpackage

// File: rtl/line_ram_arbiter_lock_timer.sv
// Counts consecutive locked grants and flags when the lock has run its allowed length.
// Count updates at the clock edge; expired is a combinational compare of the held count.
// No flow control; clear and inc together load a count of 1 (a fresh lock).
module lock_timer #(
   parameter int MAX_LOCK = 16
) (
   input  logic clock,
   input  logic clear,
   input  logic inc,
   output logic expired
);
   // Wide enough to hold MAX_LOCK; with MAX_LOCK=0 the count may wrap, which is harmless
   localparam int CNT_W = (MAX_LOCK < 2) ? 1 : $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_LOCK);

   logic [CNT_W-1:0] cnt;

   // Restart (to 0, or 1 when a new lock starts) on clear, otherwise step per locked grant
   always_ff @(posedge clock) begin
      if (clear) begin
         cnt <= inc ? CNT_W'(1) : '0;
      end else if (inc) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expired = (MAX_LOCK != 0) && (cnt == LIMIT);
endmodule

// File: rtl/line_ram_arbiter.sv
// Round-robin arbiter with optional bounded lock sharing one single-port line-buffer RAM.
// Grant is combinational in the request cycle; read data returns one cycle after the grant.
// A losing requester simply sees gnt=0 and must hold its request until granted.
module line_ram_arbiter
   import line_ram_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_LOCK = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              a_req,
   input  logic              a_lock,
   input  logic              a_write,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_lock,
   input  logic              b_write,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              ram_write,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data_in,
   input  logic [DATA_W-1:0] ram_data_out
);
   logic [1:0] owner;
   logic [1:0] last;
   logic       expired;
   logic       hold_a;
   logic       hold_b;
   logic       lock_continue;
   logic       lock_inc;
   logic       lock_clear;

   // The owner keeps the RAM only while still requesting and within its lock budget
   assign hold_a = (owner == OWN_A) && a_req && !expired;
   assign hold_b = (owner == OWN_B) && b_req && !expired;

   // Pick this cycle's winner: held lock first, then sole requester, then whoever was not served last
   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (reset) begin
         a_gnt = 1'b0;
         b_gnt = 1'b0;
      end else if (hold_a) begin
         a_gnt = 1'b1;
      end else if (hold_b) begin
         b_gnt = 1'b1;
      end else if (a_req && b_req) begin
         if (last == OWN_B) a_gnt = 1'b1;
         else               b_gnt = 1'b1;
      end else if (a_req) begin
         a_gnt = 1'b1;
      end else if (b_req) begin
         b_gnt = 1'b1;
      end
   end

   // Steer the winner's access onto the RAM; idle cycles drive all-zero
   always_comb begin
      ram_write   = 1'b0;
      ram_addr    = '0;
      ram_data_in = '0;
      if (a_gnt) begin
         ram_write   = a_write;
         ram_addr    = a_addr;
         ram_data_in = a_wdata;
      end else if (b_gnt) begin
         ram_write   = b_write;
         ram_addr    = b_addr;
         ram_data_in = b_wdata;
      end
   end

   // A lock run only continues when the current owner is re-granted under rule 1 and asks again
   assign lock_continue = (a_gnt && hold_a && a_lock) || (b_gnt && hold_b && b_lock);
   assign lock_inc      = (a_gnt && a_lock) || (b_gnt && b_lock);
   assign lock_clear    = reset || !lock_continue;

   lock_timer #(
      .MAX_LOCK (MAX_LOCK)
   ) u_lock_timer (
      .clock   (clock),
      .clear   (lock_clear),
      .inc     (lock_inc),
      .expired (expired)
   );

   // Track ownership, round-robin history and one-cycle read-valid pulses
   always_ff @(posedge clock) begin
      if (reset) begin
         owner    <= OWN_NONE;
         last     <= OWN_B;
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
      end else begin
         a_rvalid <= a_gnt && !a_write;
         b_rvalid <= b_gnt && !b_write;
         if (a_gnt) begin
            last  <= OWN_A;
            owner <= a_lock ? OWN_A : OWN_NONE;
         end else if (b_gnt) begin
            last  <= OWN_B;
            owner <= b_lock ? OWN_B : OWN_NONE;
         end else begin
            owner <= OWN_NONE;
         end
      end
   end

   // Both requesters see the RAM output; only their own rvalid qualifies it
   assign a_rdata = ram_data_out;
   assign b_rdata = ram_data_out;
endmodule

// File: tb/tb_line_ram_arbiter.sv
// Self-checking bench: directed vector table, reset-mid-lock sequence, then randomized traffic vs a reference model.
// Outputs are sampled 1 time unit after the falling edge; inputs change just after the falling edge.
// The bench models the RAM itself so read data can be checked end to end.
module tb_line_ram_arbiter;
   localparam int LIM = 4;

   typedef struct {
      logic       a_req, a_lock, a_write;
      logic [7:0] a_addr, a_wdata;
      logic       b_req, b_lock, b_write;
      logic [7:0] b_addr, b_wdata;
      logic       ea, eb;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       a_req, a_lock, a_write, b_req, b_lock, b_write;
   logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
   logic       a_gnt, a_rvalid, b_gnt, b_rvalid, ram_write;
   logic [7:0] a_rdata, b_rdata, ram_addr, ram_data_in;
   logic [7:0] ram_data_out = 8'h00;

   logic [7:0] ram [256];
   logic [7:0] ref_mem [256];
   logic       exp_a_rv, exp_b_rv;
   logic [7:0] exp_rd;
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clock = ~clock;

   line_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_LOCK(LIM)) dut (
      .clock(clock), .reset(reset),
      .a_req(a_req), .a_lock(a_lock), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_lock(b_lock), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .ram_write(ram_write), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
      .ram_data_out(ram_data_out)
   );

   // Single-port RAM: synchronous write, registered read address
   always @(posedge clock) begin
      if (ram_write) ram[ram_addr] <= ram_data_in;
      ram_data_out <= ram[ram_addr];
   end

   function automatic vec_t mk(logic ar, logic al, logic aw, logic [7:0] aa, logic [7:0] ad,
                               logic br, logic bl, logic bw, logic [7:0] ba, logic [7:0] bd,
                               logic ea, logic eb);
      vec_t v;
      v.a_req = ar; v.a_lock = al; v.a_write = aw; v.a_addr = aa; v.a_wdata = ad;
      v.b_req = br; v.b_lock = bl; v.b_write = bw; v.b_addr = ba; v.b_wdata = bd;
      v.ea = ea; v.eb = eb;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      a_req = v.a_req; a_lock = v.a_lock; a_write = v.a_write; a_addr = v.a_addr; a_wdata = v.a_wdata;
      b_req = v.b_req; b_lock = v.b_lock; b_write = v.b_write; b_addr = v.b_addr; b_wdata = v.b_wdata;
   endtask

   task automatic check_outputs(input string tag, input vec_t v, input logic ea, input logic eb);
      logic       ew;
      logic [7:0] eaddr, edin;
      ew    = ea ? v.a_write : (eb ? v.b_write : 1'b0);
      eaddr = ea ? v.a_addr  : (eb ? v.b_addr  : 8'h00);
      edin  = ea ? v.a_wdata : (eb ? v.b_wdata : 8'h00);
      chk({tag, " a_gnt"}, a_gnt, ea);
      chk({tag, " b_gnt"}, b_gnt, eb);
      chk({tag, " ram_write"}, ram_write, ew);
      chk({tag, " ram_addr"}, ram_addr, eaddr);
      chk({tag, " ram_data_in"}, ram_data_in, edin);
      chk({tag, " a_rvalid"}, a_rvalid, exp_a_rv);
      chk({tag, " b_rvalid"}, b_rvalid, exp_b_rv);
      if (exp_a_rv) chk({tag, " a_rdata"}, a_rdata, exp_rd);
      if (exp_b_rv) chk({tag, " b_rdata"}, b_rdata, exp_rd);
   endtask

   // Apply expected access to the reference memory and schedule expected read returns
   task automatic commit(input vec_t v, input logic ea, input logic eb);
      exp_a_rv = ea && !v.a_write;
      exp_b_rv = eb && !v.b_write;
      if (exp_a_rv) exp_rd = ref_mem[v.a_addr];
      if (exp_b_rv) exp_rd = ref_mem[v.b_addr];
      if (ea && v.a_write) ref_mem[v.a_addr] = v.a_wdata;
      if (eb && v.b_write) ref_mem[v.b_addr] = v.b_wdata;
   endtask

   task automatic step(input string tag, input vec_t v, input logic ea, input logic eb);
      drive(v);
      #1;
      check_outputs(tag, v, ea, eb);
      @(posedge clock);
      commit(v, ea, eb);
      @(negedge clock);
   endtask

   vec_t tbl [19];
   vec_t idle_v;

   initial begin
      vec_t v;
      int   m_owner, m_last, m_run, held, win;
      logic lk, lim_hit;

      for (int i = 0; i < 256; i++) begin
         ram[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
      exp_a_rv = 1'b0; exp_b_rv = 1'b0; exp_rd = 8'h00;
      idle_v = mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0);

      //        A: req lock wr addr  data    B: req lock wr addr  data   expA expB
      tbl[0]  = mk(1,0,1,8'h01,8'h41,  0,0,0,8'h00,8'h00, 1,0);  // A writes 0x41 @1
      tbl[1]  = mk(0,0,0,8'h00,8'h00,  1,0,0,8'h01,8'h00, 0,1);  // B reads @1
      tbl[2]  = mk(0,0,0,8'h00,8'h00,  1,0,1,8'h02,8'hC3, 0,1);  // B write, B's data returns
      tbl[3]  = mk(1,0,0,8'h01,8'h00,  1,0,0,8'h02,8'h00, 1,0);  // tie: alternate A,B,A,B
      tbl[4]  = mk(1,0,0,8'h01,8'h00,  1,0,0,8'h02,8'h00, 0,1);
      tbl[5]  = mk(1,0,0,8'h01,8'h00,  1,0,0,8'h02,8'h00, 1,0);
      tbl[6]  = mk(1,0,0,8'h01,8'h00,  1,0,0,8'h02,8'h00, 0,1);
      tbl[7]  = mk(1,1,0,8'h01,8'h00,  1,0,1,8'h03,8'h77, 1,0);  // A locks 3 cycles
      tbl[8]  = mk(1,1,0,8'h01,8'h00,  1,0,1,8'h03,8'h77, 1,0);
      tbl[9]  = mk(1,1,0,8'h01,8'h00,  1,0,1,8'h03,8'h77, 1,0);
      tbl[10] = mk(0,0,0,8'h00,8'h00,  1,0,1,8'h03,8'h77, 0,1);  // A lets go, B served
      tbl[11] = mk(1,1,0,8'h01,8'h00,  1,0,0,8'h03,8'h00, 1,0);  // lock runs to the limit
      tbl[12] = mk(1,1,0,8'h01,8'h00,  1,0,0,8'h03,8'h00, 1,0);
      tbl[13] = mk(1,1,0,8'h01,8'h00,  1,0,0,8'h03,8'h00, 1,0);
      tbl[14] = mk(1,1,0,8'h01,8'h00,  1,0,0,8'h03,8'h00, 1,0);
      tbl[15] = mk(1,1,0,8'h01,8'h00,  1,0,0,8'h03,8'h00, 0,1);  // forced release: B
      tbl[16] = mk(1,1,0,8'h01,8'h00,  1,0,0,8'h03,8'h00, 1,0);  // A relocks
      tbl[17] = mk(1,1,0,8'h01,8'h00,  1,0,0,8'h03,8'h00, 1,0);  // and still owns it
      tbl[18] = idle_v;

      // Reset state, with both requesting: nothing may be granted
      reset = 1'b1;
      drive(idle_v);
      repeat (2) @(posedge clock);
      @(negedge clock);
      v = mk(1,0,1,8'h05,8'h11, 1,0,1,8'h06,8'h22, 0,0);
      drive(v);
      #1;
      check_outputs("reset", v, 1'b0, 1'b0);
      @(posedge clock);
      commit(v, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 19; i++) step($sformatf("vec%0d", i), tbl[i], tbl[i].ea, tbl[i].eb);

      // Reset while A holds a lock and a read is returning
      step("rst_seq0", mk(1,1,0,8'h01,8'h00, 0,0,0,8'h00,8'h00, 0,0), 1'b1, 1'b0);
      reset = 1'b1;
      step("rst_seq1", mk(1,1,1,8'h05,8'h11, 1,0,1,8'h06,8'h22, 0,0), 1'b0, 1'b0);
      reset = 1'b0;
      step("rst_seq2", mk(1,0,0,8'h01,8'h00, 1,0,0,8'h02,8'h00, 0,0), 1'b1, 1'b0);
      step("rst_seq3", idle_v, 1'b0, 1'b0);

      // Randomized traffic against the rule-level reference model
      reset = 1'b1;
      step("rand_rst", idle_v, 1'b0, 1'b0);
      reset = 1'b0;
      m_owner = 0; m_last = 2; m_run = 0;
      for (int n = 0; n < 1500; n++) begin
         v.a_req   = ($urandom_range(0, 3) != 0);
         v.a_lock  = ($urandom_range(0, 9) < 7);
         v.a_write = $urandom_range(0, 1);
         v.a_addr  = 8'($urandom_range(0, 15));
         v.a_wdata = 8'($urandom);
         v.b_req   = ($urandom_range(0, 3) != 0);
         v.b_lock  = ($urandom_range(0, 9) < 7);
         v.b_write = $urandom_range(0, 1);
         v.b_addr  = 8'($urandom_range(0, 15));
         v.b_wdata = 8'($urandom);

         lim_hit = (LIM != 0) && (m_run == LIM);
         held = 0;
         if (m_owner == 1 && v.a_req && !lim_hit) held = 1;
         else if (m_owner == 2 && v.b_req && !lim_hit) held = 2;
         if (held != 0)                win = held;
         else if (v.a_req && v.b_req)  win = (m_last == 1) ? 2 : 1;
         else if (v.a_req)             win = 1;
         else if (v.b_req)             win = 2;
         else                          win = 0;
         v.ea = (win == 1);
         v.eb = (win == 2);

         step("rand", v, v.ea, v.eb);

         if (win != 0) begin
            m_last = win;
            lk = (win == 1) ? v.a_lock : v.b_lock;
            if (lk) begin
               m_run   = (held == win) ? m_run + 1 : 1;
               m_owner = win;
            end else begin
               m_owner = 0;
               m_run   = 0;
            end
         end else begin
            m_owner = 0;
            m_run   = 0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/line_ram_arbiter.md
Name: line_ram_arbiter

Overview:
Shares the single-port 256x8 line-buffer RAM (synchronous write, registered read address) between two requesters. Requester A is the line receiver that writes incoming bytes. Requester B is the line consumer, a parser or transmitter that reads the stored line back. Arbitration is round-robin, and an optional lock lets one requester own the RAM for a multi-cycle burst. A lock-length limit guarantees the other requester is not starved.

Parameters:
ADDR_W, 8, RAM address width.
DATA_W, 8, RAM data width.
MAX_LOCK, 16, maximum consecutive granted cycles under lock before a forced release; 0 = unlimited.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
a_req  in  1  A requests an access this cycle.
a_lock  in  1  A wants to keep ownership after this access.
a_write  in  1  1 = write, 0 = read.
a_addr  in  ADDR_W  A access address.
a_wdata  in  DATA_W  A write data.
a_gnt  out  1  A's access is performed at this rising edge.
a_rvalid  out  1  a_rdata is valid (read granted on the previous cycle).
a_rdata  out  DATA_W  read data for A.
b_req, b_lock, b_write, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A ports, for requester B.
ram_write  out  1  RAM write enable.
ram_addr  out  ADDR_W  RAM address.
ram_data_in  out  DATA_W  RAM write data.
ram_data_out  in  DATA_W  RAM read data, valid the cycle after the address edge.

Behaviour:
- Registered state:
  - owner: NONE, A or B.
  - last: the requester served most recently.
  - lock_cnt: number of consecutive locked grants.
  - a_rvalid, b_rvalid.
- Reset values: owner=NONE, last=B (so A wins the first tie), lock_cnt=0, both rvalid=0.
- While reset is high, both gnt outputs are 0 and ram_write is 0.
- Grant decision is combinational and made every cycle:
  1. If owner is X, x_req=1, and the lock has not expired, then grant X. The other requester waits.
  2. Otherwise, if exactly one req is high, grant it.
  3. If both reqs are high, grant the requester that is not `last`.
  4. If no req is high, grant nobody.
- Lock expiry: MAX_LOCK != 0 and lock_cnt == MAX_LOCK.
- RAM drive:
  - ram_addr, ram_data_in and ram_write are muxed from the granted requester.
  - ram_write = granted x_write.
  - With no grant: ram_write=0, ram_addr=0, ram_data_in=0.
- At the edge, when X is granted:
  - last <= X.
  - If x_lock=1: owner <= X. lock_cnt <= lock_cnt+1 if X was already owner, otherwise 1.
  - If x_lock=0: owner <= NONE and lock_cnt <= 0.
- At the edge, with no grant: owner <= NONE and lock_cnt <= 0.
- Owner drops req while holding lock: ownership is lost immediately that cycle. Rule 1 fails and normal arbitration applies.
- Forced release on lock expiry:
  - Treated as if the owner had x_lock=0 for that arbitration: the cycle falls to rules 2-3.
  - The other requester wins if it is requesting.
  - If the other requester is idle, the owner is re-granted and lock_cnt restarts at 1.
- Read latency:
  - x_rvalid is high for exactly 1 cycle, the cycle after a granted read with x_write=0.
  - x_rdata = ram_data_out, wired to both requesters. Only the matching rvalid qualifies the data.
  - Writes never raise rvalid.
- Back-to-back reads by alternating requesters: rvalid pulses alternate cycle by cycle, with no bubbles.
- Throughput: at most one access per cycle and no idle cycle between grants.
- Reset asserted mid-lock: the in-flight state is discarded. On the next cycle owner=NONE and a pending rvalid is cleared to 0.

Decomposition:
- Package line_ram_pkg:
  - owner encoding constants OWN_NONE=2'd0, OWN_A=2'd1, OWN_B=2'd2.
  - default ADDR_W/DATA_W.
- One natural sub-module, lock_timer:
  - holds the lock_cnt counter and its expiry compare.
  - inputs: clear, inc; output: expired.
  - MAX_LOCK is passed through.
- Everything else stays in line_ram_arbiter.

Test Plan:
- A only, write 0x41 to address 0x01 → a_gnt=1 in the same cycle, ram_write=1, ram_addr=0x01, ram_data_in=0x41; a_rvalid stays 0.
- B reads 0x01 after the write above → b_gnt=1; one cycle later b_rvalid=1 and b_rdata=0x41; a_rvalid=0 throughout.
- Both req, no lock, held 4 cycles → grants go A,B,A,B (first tie to A after reset).
- A holds a_lock=1 with req for 3 cycles while B requests, MAX_LOCK=16 → A is granted 3 cycles. A then drops lock → B is granted on cycle 4.
- MAX_LOCK=4, A locked and B requesting continuously → A granted 4 cycles, B granted cycle 5, A regains ownership on cycle 6.
- Reset pulsed while A is locked with a read granted the prior cycle → no gnt during reset, a_rvalid=0 after reset, first tie afterwards goes to A.
